// File: rtl/repsub_divider.sv
// Unsigned divider using repeated subtraction, one subtract per cycle.
// Dividend and divisor arrive on one shared bus on consecutive cycles.
module repsub_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             busy,
    output logic             div_by_zero
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        CHECK,
        SUB,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] diff;

    // Only consumed in SUB, where remainder >= divisor holds.
    assign diff = remainder - divisor;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and state-decoded strobes.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        busy      = (state != IDLE);
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD_A;
                end
            end
            LOAD_A: state_nxt = LOAD_B;
            LOAD_B: state_nxt = CHECK;
            CHECK: begin
                if (divisor == '0) begin
                    state_nxt = DONE;
                end else if (remainder < divisor) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = SUB;
                end
            end
            SUB: begin
                if (diff < divisor) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture and the subtract/count datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient    <= '0;
            remainder   <= '0;
            divisor     <= '0;
            div_by_zero <= 1'b0;
        end else begin
            unique case (state)
                LOAD_A: begin
                    remainder   <= data_in;
                    quotient    <= '0;
                    div_by_zero <= 1'b0;
                end
                LOAD_B: begin
                    divisor <= data_in;
                end
                CHECK: begin
                    if (divisor == '0) begin
                        div_by_zero <= 1'b1;
                        quotient    <= '1;
                    end
                end
                SUB: begin
                    remainder <= diff;
                    quotient  <= quotient + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_repsub_divider.sv
// Scoreboard bench for repsub_divider.
// Checks results, done latency, busy, reset abort and hold behaviour.
module tb_repsub_divider;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           at_cyc;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] data_in;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         done;
    logic         busy;
    logic         div_by_zero;

    exp_t         sb[$];
    int           checks;
    int           errors;
    int           cyc;
    int           done_cnt;
    int           busy_gaps;
    logic [W-1:0] last_q;
    logic [W-1:0] last_r;

    repsub_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .data_in    (data_in),
        .quotient   (quotient),
        .remainder  (remainder),
        .done       (done),
        .busy       (busy),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Monitor: busy must stay high while a job is in flight; done pops.
    always @(negedge clk) begin
        if (rst_n && sb.size() != 0 && !busy) busy_gaps++;
        if (rst_n && done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("spurious_done", 64'(done), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", 64'(quotient), 64'(e.q));
                chk("remainder", 64'(remainder), 64'(e.r));
                chk("div_by_zero", 64'(div_by_zero), 64'(e.dz));
                chk("latency", 64'(cyc), 64'(e.at_cyc));
            end
        end
    end

    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   n;
        @(negedge clk);
        start   = 1'b1;
        data_in = W'($urandom);
        @(negedge clk);
        start   = 1'b0;
        data_in = a;
        if (b == 0) begin
            e.q  = '1;
            e.r  = a;
            e.dz = 1'b1;
            n    = 0;
        end else begin
            e.q  = a / b;
            e.r  = a % b;
            e.dz = 1'b0;
            n    = int'(a / b);
        end
        e.at_cyc = cyc + 3 + n;
        last_q   = e.q;
        last_r   = e.r;
        sb.push_back(e);
        @(negedge clk);
        data_in = b;
        @(negedge clk);
        data_in = W'($urandom);
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (sb.size() != 0 && n < limit) begin
            @(negedge clk);
            data_in = W'($urandom);
            n++;
        end
        if (sb.size() != 0) begin
            chk("timeout", 64'(sb.size()), 64'(0));
            sb.delete();
        end
        repeat (3) begin
            @(negedge clk);
            data_in = W'($urandom);
        end
        chk("hold_q", 64'(quotient), 64'(last_q));
        chk("hold_r", 64'(remainder), 64'(last_r));
    endtask

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b,
                       input int limit);
        launch(a, b);
        wait_idle(limit);
    endtask

    initial begin
        int exp_dones;
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        done_cnt  = 0;
        busy_gaps = 0;
        exp_dones = 0;
        start     = 1'b0;
        data_in   = '0;
        rst_n     = 1'b0;
        start     = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_q", 64'(quotient), 64'(0));
        chk("rst_r", 64'(remainder), 64'(0));
        chk("rst_dz", 64'(div_by_zero), 64'(0));
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_rst", 64'(busy), 64'(0));

        run(16'd100, 16'd7, 100);
        run(16'd5, 16'd9, 100);
        run(16'd1234, 16'd0, 100);
        run(16'd77, 16'd77, 100);
        run(16'd0, 16'd5, 100);
        run(16'd0, 16'd0, 100);
        exp_dones += 6;
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = W'($urandom);
            b = W'($urandom_range(200, 65535));
            run(a, b, 400);
            exp_dones++;
        end
        run(16'hFFFF, 16'd1, 70000);
        exp_dones++;

        // Abort a long division by reset mid-SUB.
        @(negedge clk);
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        data_in = 16'd1000;
        @(negedge clk);
        data_in = 16'd3;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        chk("abort_q", 64'(quotient), 64'(0));
        chk("abort_r", 64'(remainder), 64'(0));
        chk("abort_dz", 64'(div_by_zero), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_idle", 64'(busy), 64'(0));
        run(16'd9, 16'd3, 100);
        exp_dones++;

        // Start pulses and bus noise while busy in SUB.
        launch(16'd5000, 16'd7);
        exp_dones++;
        repeat (20) begin
            @(negedge clk);
            start   = 1'($urandom);
            data_in = W'($urandom);
        end
        start = 1'b0;
        wait_idle(1000);
        repeat (5) @(negedge clk);

        chk("done_count", 64'(done_cnt), 64'(exp_dones));
        chk("busy_gaps", 64'(busy_gaps), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/repsub_divider.md
REPSUB_DIVIDER -- requirements
Module: repsub_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 16, setting the operand, quotient and remainder width.
REQ-002 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-005 SHALL have port data_in, input, WIDTH bits: shared operand bus; carries the dividend, then the divisor, on consecutive cycles.
REQ-006 SHALL have port quotient, output, WIDTH bits: registered quotient.
REQ-007 SHALL have port remainder, output, WIDTH bits: registered remainder.
REQ-008 SHALL have port done, output, 1 bit: single-cycle result-valid strobe.
REQ-009 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 SHALL have port div_by_zero, output, 1 bit: registered flag, set when the divisor is 0.

Function
REQ-011 SHALL compute dividend / divisor, both unsigned, by repeated subtraction: one subtract per cycle.
REQ-012 SHALL implement states IDLE, LOAD_A, LOAD_B, CHECK, SUB and DONE, with registered state.
REQ-013 SHALL move IDLE -> LOAD_A on a clock edge with start=1.
- start is ignored in every other state.
REQ-014 SHALL, in LOAD_A:
- load remainder <= data_in (dividend);
- clear quotient to 0 and div_by_zero to 0;
- go to LOAD_B.
REQ-015 SHALL, in LOAD_B, capture data_in into an internal divisor register, then go to CHECK.
REQ-016 SHALL, in CHECK:
- if divisor==0: set div_by_zero=1, quotient=all-ones, remainder unchanged (= dividend), go to DONE;
- else if remainder<divisor: go to DONE;
- else: go to SUB.
REQ-017 SHALL, in SUB, on each edge:
- update remainder <= remainder-divisor and quotient <= quotient+1;
- go to DONE when (remainder-divisor) < divisor, else stay in SUB.
REQ-018 SHALL hold done=1 for exactly one cycle, in DONE, then go to IDLE.
REQ-019 SHALL use only full-width unsigned compares and subtraction.
- Subtraction never underflows, because it is guarded by the compare.
- The quotient never wraps; maximum count is 2^WIDTH-1 (divisor=1).
REQ-020 SHALL set latency as follows. With start sampled at edge k, dividend at edge k+1, divisor at edge k+2 and N=floor(dividend/divisor):
- done is high in the cycle following edge k+3+N;
- for divisor=0, N=0.
REQ-021 SHALL keep quotient, remainder and div_by_zero stable from DONE until the next LOAD_A.
REQ-022 SHALL ignore data_in in every state other than LOAD_A and LOAD_B.
REQ-023 SHALL accept start asserted in the cycle done is high only if it is still high at the next IDLE edge; there is no back-to-back start during DONE.

Reset
REQ-024 SHALL, on rst_n=0 and regardless of clk:
- force state to IDLE;
- force quotient, remainder, divisor register and div_by_zero to 0;
- force done and busy to 0.
REQ-025 SHALL abort any operation in progress when reset is asserted mid-operation; no done is produced for the aborted division.
REQ-026 SHALL hold state in IDLE while rst_n=0 and leave IDLE only on a start sampled after rst_n deasserts.

Verification
REQ-027 Basic: start, then 100, then 7 -> done in the cycle after edge k+17; quotient=14, remainder=2, div_by_zero=0.
REQ-028 Zero quotient: start, then 5, then 9 -> done in the cycle after edge k+3; quotient=0, remainder=5.
REQ-029 Divide by zero: start, then 1234, then 0 -> done after edge k+3; div_by_zero=1, quotient=16'hFFFF, remainder=1234.
REQ-030 Maximum iterations: start, then 16'hFFFF, then 1 -> done after edge k+65538; quotient=16'hFFFF, remainder=0, busy high throughout.
REQ-031 Reset mid-SUB: start, then 1000, then 3; rst_n low 10 cycles later:
- immediately: busy=0, outputs=0, no done;
- afterwards, start, then 9, then 3 -> quotient=3, remainder=0.
REQ-032 Start while busy plus bus noise:
- start is pulsed during SUB and data_in is toggled outside the load cycles;
- the result is unchanged from the reference division, and exactly one done pulse occurs.
